cdb_slot_scheduler: RTL

Issue-stage scheduler that reserves future CDB broadcast slots for fixed-latency functional units so their results never contend at the CDB arbiter. It sits between the issue logic and the FUs. Each cycle it grants issue to at most as many same-latency requests as there are unreserved CDB lanes in the target cycle. It also reports the lanes left over in the current cycle as a budget for variable-latency units (loads), which the issue/FU side uses to throttle `fu_done`. The intent is that `stall_sig` from the CDB stays low for all fixed-latency FUs.

---
 rtl/cdb_slot_scheduler.sv | 109 ++++++++++
 1 files changed

// File: rtl/cdb_slot_scheduler.sv
`default_nettype none

`ifndef N
`define N 2
`endif

// ============================================================================
//  Module   : cdb_slot_scheduler
//  Purpose  : Reserves future CDB broadcast lanes for fixed-latency FUs at
//             issue time, so their results never contend at the CDB arbiter.
//             It also reports the lanes left free in the current cycle as a
//             budget for variable-latency units.
//  Ports    : clock      - system clock
//             reset      - asynchronous active-high, clears the table
//             flush      - synchronous full flush: no grants, table cleared
//             req        - per-requester issue request
//             req_lat    - per-requester latency, C_LW bits each
//             gnt        - per-requester grant (combinational)
//             var_budget - N - res[0], free lanes in the current cycle
//             res_count  - packed reservation table, slot k at [k*C_CW +: C_CW]
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_slot_scheduler #(
    parameter  int N       = `N,
    parameter  int NUM_REQ = 4,
    parameter  int MAX_LAT = 4,
    localparam int C_CW    = $clog2(N + 1),
    localparam int C_LW    = $clog2(MAX_LAT + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*C_LW-1:0]       req_lat,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [C_CW-1:0]               var_budget,
    output logic [(MAX_LAT+1)*C_CW-1:0]   res_count
);

    localparam logic [C_CW-1:0] C_N     = C_CW'(N);
    localparam logic [C_CW:0]   C_N_EXT = {1'b0, C_N};

    // r_res[k]: lanes already reserved for cycle t+k. Slot MAX_LAT is held
    // at zero at every cycle start; it only exists so latency MAX_LAT grants
    // have a slot to count against.
    logic [C_CW-1:0]    r_res [0:MAX_LAT];

    // w_g[L]: grants made this cycle for latency L.
    logic [C_CW-1:0]    w_g   [1:MAX_LAT];
    logic [NUM_REQ-1:0] w_gnt;

    // Fixed priority, lowest index first. Latencies are matched against each
    // legal value explicitly, so a latency of 0 or above MAX_LAT never
    // matches and is silently ignored.
    always_comb begin
        for (int k = 1; k <= MAX_LAT; k++) begin
            w_g[k] = '0;
        end
        w_gnt = '0;
        if (!reset && !flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int k = 1; k <= MAX_LAT; k++) begin
                    if (req[i] && (req_lat[i*C_LW +: C_LW] == C_LW'(k))) begin
                        if (({1'b0, r_res[k]} + {1'b0, w_g[k]}) < C_N_EXT) begin
                            w_gnt[i] = 1'b1;
                            w_g[k]   = w_g[k] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // The table shifts toward "now" each cycle, merging this cycle's grants
    // into the slot they will occupy after the shift.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= MAX_LAT; k++) begin
                r_res[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k <= MAX_LAT; k++) begin
                r_res[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAX_LAT; k++) begin
                r_res[k] <= r_res[k+1] + w_g[k+1];
            end
            r_res[MAX_LAT] <= '0;
        end
    end

    assign gnt        = w_gnt;
    assign var_budget = C_N - r_res[0];

    generate
        for (genvar k = 0; k <= MAX_LAT; k++) begin : g_pack
            assign res_count[k*C_CW +: C_CW] = r_res[k];
        end

        for (genvar k = 0; k <= MAX_LAT; k++) begin : g_res_chk
            a_res_bound: assert property (@(posedge clock) disable iff (reset)
                                          r_res[k] <= C_N);
        end
    endgenerate

endmodule

`default_nettype wire
